// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the four-way round-robin packet arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int NUM_REQ = 4;

  // Watchdog counter width: enough to hold TIMEOUT itself, never narrower than one bit.
  function automatic int wd_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first set request scanning ptr, ptr+1, ... mod 4.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic               found_o,
  output logic [1:0]         idx_o
);

  logic [1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    cand    = ptr_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr_i + 2'(k);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin packet arbiter with grant hold until last beat and an idle watchdog.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic [1:0]                 sel,
  output logic                       abort
);

  localparam int              WD_W   = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  state_e               state_q;
  logic [1:0]           ptr_q;
  logic [1:0]           sel_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [WD_W-1:0]      wd_q;
  logic                 abort_q;

  logic                 pick_found;
  logic [1:0]           pick_idx;
  logic                 busy;
  logic                 cur_valid;
  logic                 cur_last;
  logic                 xfer;
  logic [WD_W-1:0]      wd_d;
  logic                 wd_hit;

  rr_pick4 u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign busy      = (state_q == BUSY);
  assign cur_valid = req_valid[sel_q];
  assign cur_last  = req_last[sel_q];
  assign xfer      = busy & cur_valid & out_ready;

  // Saturating idle count; the abort decision fires on the edge where it reaches TIMEOUT.
  assign wd_d   = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
  assign wd_hit = (TIMEOUT > 0) && busy && !cur_valid && (wd_d == WD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      grant_q <= '0;
      wd_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (pick_found) begin
            sel_q   <= pick_idx;
            grant_q <= NUM_REQ'(1) << pick_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (xfer && cur_last) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= sel_q + 2'd1;
            wd_q    <= '0;
          end else if (wd_hit) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= sel_q + 2'd1;
            wd_q    <= '0;
            abort_q <= 1'b1;
          end else if (cur_valid) begin
            wd_q <= '0;
          end else begin
            wd_q <= wd_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Steering is purely combinational; everything reads zero outside BUSY.
  always_comb begin
    out_data = '0;
    if (busy) out_data = req_data[sel_q*WIDTH +: WIDTH];
  end

  assign out_valid = busy & cur_valid;
  assign out_last  = busy & cur_last;
  assign req_ready = {NUM_REQ{out_ready}} & grant_q;
  assign grant     = grant_q;
  assign sel       = sel_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: stimulus queues expected beats/aborts, a monitor pops them.
module tb_rr_arbiter_4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        abort;

  typedef struct {
    bit         is_abort;
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   beat_cnt = 0;

  rr_arbiter_4 #(.WIDTH(8), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]       = v;
    req_data[i*8 +: 8] = d;
    req_last[i]        = l;
  endtask

  task automatic push_beat(input logic [1:0] s, input logic [7:0] d, input logic l);
    exp_t e;
    e.is_abort = 1'b0;
    e.sel      = s;
    e.data     = d;
    e.last     = l;
    q.push_back(e);
  endtask

  task automatic push_abort();
    exp_t e;
    e.is_abort = 1'b1;
    e.sel      = 2'd0;
    e.data     = 8'd0;
    e.last     = 1'b0;
    q.push_back(e);
  endtask

  // Monitor: every accepted beat and every abort pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (q.size() == 0) begin
          chk("beat_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("beat_kind", {31'd0, e.is_abort}, 32'd0);
          chk("beat_sel", {30'd0, sel}, {30'd0, e.sel});
          chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
          chk("beat_last", {31'd0, out_last}, {31'd0, e.last});
          chk("beat_grant", {28'd0, grant}, 32'(4'b0001 << e.sel));
        end
      end
      if (abort) begin
        if (q.size() == 0) begin
          chk("abort_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("abort_kind", {31'd0, e.is_abort}, 32'd1);
        end
      end
    end
  end

  initial begin
    int first_at;
    int n_abort;

    // Reset with every requester asking.
    rst_n     = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'h0;
    req_data  = 32'h0;
    req_last  = 4'h0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'h10 + 8'(i), 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_abort", {31'd0, abort}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);

    // Fairness: continuous single-beat packets rotate 0,1,2,3,0 at one per two cycles.
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_beat(2'd0, 8'h10, 1'b1);
    push_beat(2'd1, 8'h11, 1'b1);
    push_beat(2'd2, 8'h12, 1'b1);
    push_beat(2'd3, 8'h13, 1'b1);
    push_beat(2'd0, 8'h10, 1'b1);
    @(negedge clk);
    chk("idle_after_release", {28'd0, grant}, 32'd0);
    tick();
    @(negedge clk);
    chk("first_grant", {28'd0, grant}, 32'h1);
    chk("first_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (9) tick();
    chk("fair_beats_10cyc", beat_cnt, 32'd5);

    // Hold: requester 2 sends A,B,C while requester 0 waits (ptr now 1).
    req_valid = 4'h0;
    set_req(0, 1'b1, 8'h55, 1'b1);
    set_req(2, 1'b1, 8'hA1, 1'b0);
    push_beat(2'd2, 8'hA1, 1'b0);
    push_beat(2'd2, 8'hB2, 1'b0);
    push_beat(2'd2, 8'hC3, 1'b1);
    push_beat(2'd0, 8'h55, 1'b1);
    tick();
    @(negedge clk);
    chk("hold_ready_A", {28'd0, req_ready}, 32'h4);
    tick();
    set_req(2, 1'b1, 8'hB2, 1'b0);
    @(negedge clk);
    chk("hold_ready_B", {28'd0, req_ready}, 32'h4);
    tick();
    set_req(2, 1'b1, 8'hC3, 1'b1);
    @(negedge clk);
    chk("hold_ready_C", {28'd0, req_ready}, 32'h4);
    tick();
    set_req(2, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("hold_gap_grant", {28'd0, grant}, 32'd0);
    tick();
    @(negedge clk);
    chk("hold_next_grant", {28'd0, grant}, 32'h1);
    tick();
    req_valid = 4'h0;

    // Back-pressure: 40 stalled cycles with valid held must not trip the watchdog.
    set_req(1, 1'b1, 8'h31, 1'b0);
    out_ready = 1'b0;
    push_beat(2'd1, 8'h31, 1'b0);
    push_beat(2'd1, 8'h32, 1'b1);
    tick();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c % 10 == 0) begin
        chk("bp_data_stable", {24'd0, out_data}, 32'h31);
        chk("bp_grant_held", {28'd0, grant}, 32'h2);
      end
      if (abort) chk("bp_no_abort", 32'd1, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    set_req(1, 1'b1, 8'h32, 1'b1);
    tick();
    req_valid = 4'h0;
    @(negedge clk);
    chk("bp_done_idle", {28'd0, grant}, 32'd0);

    // Watchdog: requester 1 (found scanning from 2) stalls after beat 1.
    set_req(1, 1'b1, 8'h41, 1'b0);
    push_beat(2'd1, 8'h41, 1'b0);
    push_abort();
    tick();
    tick();
    set_req(1, 1'b0, 8'h41, 1'b0);
    first_at = 0;
    n_abort  = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (abort) begin
        n_abort++;
        if (first_at == 0) first_at = k;
        chk("wd_idle_on_abort", {28'd0, grant}, 32'd0);
      end
      tick();
    end
    chk("wd_abort_cycle", first_at, 32'd17);
    chk("wd_abort_count", n_abort, 32'd1);
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'h60 + 8'(i), 1'b1);
    push_beat(2'd2, 8'h62, 1'b1);
    tick();
    @(negedge clk);
    chk("wd_next_grant", {28'd0, grant}, 32'h4);
    tick();
    req_valid = 4'h0;

    // Async reset while requester 3 presents beat 2 of 4.
    set_req(3, 1'b1, 8'h71, 1'b0);
    push_beat(2'd3, 8'h71, 1'b0);
    tick();
    tick();
    set_req(3, 1'b1, 8'h72, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_grant", {28'd0, grant}, 32'd0);
    chk("arst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("arst_out_data", {24'd0, out_data}, 32'd0);
    chk("arst_sel", {30'd0, sel}, 32'd0);
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'h80 + 8'(i), 1'b1);
    push_beat(2'd0, 8'h80, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("arst_restart_grant", {28'd0, grant}, 32'h1);
    tick();
    req_valid = 4'h0;
    repeat (3) tick();
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
